// File: rtl/ceespu_bp_update_ctrl.sv
// ceespu_bp_update_ctrl
//   Schedules every write into the gshare predictor table. Resolved conditional
//   branches from execute go into a small FIFO, and one entry per cycle is retired
//   to the predictor as a table/history update. After reset, or when I_clear is
//   seen, an init sweep writes every table entry to weakly-taken.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   SWEEP | init sweep: O_init_index steps 0..2**TABLE_BITS-1, queue closed
//   RUN   | queue open; the head is popped to O_upd_* whenever non-empty
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   I_res_valid/addr/state/taken resolved branch from execute
//   O_res_ready                 queue accepts I_res_* this cycle
//   I_clear                     flush queue and restart the init sweep
//   O_upd_valid/addr/state/taken update strobe and fields to the predictor
//   O_init_valid/O_init_index   sweep write strobe and entry index
//   O_busy                      sweep in progress
//   O_mispred_cnt               saturating count of retired mispredictions
module ceespu_bp_update_ctrl #(
  parameter int DEPTH_LOG2 = 2,
  parameter int TABLE_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  I_res_valid,
  input  logic [15:0]           I_res_addr,
  input  logic [1:0]            I_res_state,
  input  logic                  I_res_taken,
  output logic                  O_res_ready,
  input  logic                  I_clear,
  output logic                  O_upd_valid,
  output logic [15:0]           O_upd_addr,
  output logic [1:0]            O_upd_state,
  output logic                  O_upd_taken,
  output logic                  O_init_valid,
  output logic [TABLE_BITS-1:0] O_init_index,
  output logic                  O_busy,
  output logic [15:0]           O_mispred_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {S_SWEEP, S_RUN} state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  state;
    logic        taken;
  } entry_t;

  state_t                state_q, state_d;
  entry_t                mem [DEPTH];
  entry_t                head;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_d;
  logic                  push, pop, mispred;

  assign head    = mem[rd_ptr];
  // Clear wins over both a concurrent push and a concurrent pop.
  assign push    = I_res_valid && O_res_ready && !I_clear;
  assign pop     = (state_q == S_RUN) && (count != '0) && !I_clear;
  assign mispred = head.state[1] != head.taken;

  always_comb begin
    state_d = state_q;
    count_d = count;
    if (I_clear) begin
      state_d = S_SWEEP;
      count_d = '0;
    end else begin
      if (state_q == S_SWEEP && O_init_index == '1) state_d = S_RUN;
      count_d = count + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: I_res_addr, state: I_res_state, taken: I_res_taken};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_SWEEP;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      O_res_ready   <= 1'b0;
      O_upd_valid   <= 1'b0;
      O_upd_addr    <= '0;
      O_upd_state   <= '0;
      O_upd_taken   <= 1'b0;
      O_init_valid  <= 1'b1;
      O_init_index  <= '0;
      O_busy        <= 1'b1;
      O_mispred_cnt <= '0;
    end else begin
      state_q      <= state_d;
      count        <= count_d;
      // Ready is a pure function of next-cycle registered state and occupancy.
      O_res_ready  <= (state_d == S_RUN) && (count_d != (DEPTH_LOG2+1)'(DEPTH));
      O_init_valid <= (state_d == S_SWEEP);
      O_busy       <= (state_d == S_SWEEP);
      O_upd_valid  <= pop;

      if (I_clear) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        O_init_index <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        // Index wraps back to 0 naturally on the last sweep cycle.
        if (state_q == S_SWEEP) O_init_index <= O_init_index + 1'b1;
      end

      if (pop) begin
        O_upd_addr  <= head.addr;
        O_upd_state <= head.state;
        O_upd_taken <= head.taken;
        if (mispred && O_mispred_cnt != 16'hFFFF) O_mispred_cnt <= O_mispred_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ceespu_bp_update_ctrl.sv
module tb_ceespu_bp_update_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_res_valid, I_res_taken, I_clear;
  logic [15:0] I_res_addr;
  logic [1:0]  I_res_state;
  logic        O_res_ready, O_upd_valid, O_upd_taken, O_init_valid, O_busy;
  logic [15:0] O_upd_addr, O_mispred_cnt;
  logic [1:0]  O_upd_state;
  logic [5:0]  O_init_index;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ceespu_bp_update_ctrl #(.DEPTH_LOG2(2), .TABLE_BITS(6)) dut (
    .clk(clk), .rst(rst),
    .I_res_valid(I_res_valid), .I_res_addr(I_res_addr), .I_res_state(I_res_state),
    .I_res_taken(I_res_taken), .O_res_ready(O_res_ready), .I_clear(I_clear),
    .O_upd_valid(O_upd_valid), .O_upd_addr(O_upd_addr), .O_upd_state(O_upd_state),
    .O_upd_taken(O_upd_taken), .O_init_valid(O_init_valid), .O_init_index(O_init_index),
    .O_busy(O_busy), .O_mispred_cnt(O_mispred_cnt)
  );

  // Reference model: a plain queue plus a sweep cycle counter.
  typedef struct {
    logic [15:0] a;
    logic [1:0]  s;
    logic        t;
  } ent_t;

  ent_t        q[$];
  bit          m_sweep;
  int          m_idx;
  bit          m_ready;
  bit          m_valid;
  logic [15:0] m_addr;
  logic [1:0]  m_state;
  logic        m_taken;
  int          m_cnt;

  task automatic model_reset();
    q.delete();
    m_sweep = 1; m_idx = 0; m_ready = 0; m_valid = 0;
    m_addr = 0; m_state = 0; m_taken = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit v, input logic [15:0] a, input logic [1:0] s,
                            input logic t, input bit c);
    ent_t e;
    if (c) begin
      q.delete(); m_valid = 0; m_sweep = 1; m_idx = 0; m_ready = 0;
    end else if (m_sweep) begin
      m_valid = 0;
      if (m_idx == 63) begin m_sweep = 0; m_idx = 0; end
      else m_idx++;
      m_ready = !m_sweep;
    end else begin
      bit accept;
      accept = v && m_ready;
      if (q.size() > 0) begin
        e = q.pop_front();
        m_valid = 1; m_addr = e.a; m_state = e.s; m_taken = e.t;
        if ((e.s >= 2) != (e.t == 1'b1) && m_cnt < 65535) m_cnt++;
      end else m_valid = 0;
      if (accept) begin
        e.a = a; e.s = s; e.t = t;
        q.push_back(e);
      end
      m_ready = q.size() < 4;
    end
  endtask

  // Drive inputs, advance the model, and move just past the next rising edge.
  task automatic step(input bit v, input logic [15:0] a, input logic [1:0] s,
                      input logic t, input bit c);
    I_res_valid = v; I_res_addr = a; I_res_state = s; I_res_taken = t; I_clear = c;
    model_edge(v, a, s, t, c);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; I_res_valid = 0; I_res_addr = 0; I_res_state = 0; I_res_taken = 0; I_clear = 0;
    model_reset();
    #22;
    n_checks++;
    if ({O_busy, O_init_valid, O_init_index, O_res_ready, O_upd_valid, O_upd_addr,
         O_upd_state, O_upd_taken, O_mispred_cnt} !== {1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 16'd0,
         2'd0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b init_v=%b idx=%0d ready=%b upd_v=%b cnt=%h, required 1 1 0 0 0 0",
               O_busy, O_init_valid, O_init_index, O_res_ready, O_upd_valid, O_mispred_cnt);
    end
    #5 rst = 0;  // released mid-cycle, away from the edge
    #1;
    n_checks++;
    if (O_init_index !== 6'd0 || O_init_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_idx: idx=%0d init_v=%b, required 0 1", O_init_index, O_init_valid);
    end
    @(posedge clk); #1;
    // First edge after release advances the model's sweep too.
    model_edge(0, 0, 0, 0, 0);
  endtask

  task automatic test_sweep();
    for (int i = 1; i < 64; i++) begin
      n_checks++;
      if (O_init_valid !== 1'b1 || O_busy !== 1'b1 || O_init_index !== 6'(i) ||
          O_res_ready !== 1'b0 || O_upd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_cycle%0d: init_v=%b busy=%b idx=%0d ready=%b upd_v=%b, required 1 1 %0d 0 0",
                 i, O_init_valid, O_busy, O_init_index, O_res_ready, O_upd_valid, i);
      end
      step(0, 0, 0, 0, 0);
    end
    n_checks++;
    if (O_busy !== 1'b0 || O_init_valid !== 1'b0 || O_res_ready !== 1'b1 || O_init_index !== 6'd0) begin
      n_fail++;
      $display("FAIL sweep_end: busy=%b init_v=%b ready=%b idx=%0d, required 0 0 1 0",
               O_busy, O_init_valid, O_res_ready, O_init_index);
    end
  endtask

  task automatic test_single();
    step(1, 16'h0040, 2'd2, 1'b0, 0);
    n_checks++;
    if (O_upd_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_latency: upd_v=%b at k, required 0", O_upd_valid);
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (O_upd_valid !== 1'b1 || O_upd_addr !== 16'h0040 || O_upd_state !== 2'd2 ||
        O_upd_taken !== 1'b0 || O_mispred_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL single_update: v=%b addr=%h st=%0d tk=%b cnt=%0d, required 1 0040 2 0 1",
               O_upd_valid, O_upd_addr, O_upd_state, O_upd_taken, O_mispred_cnt);
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (O_upd_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drop: upd_v=%b, required 0", O_upd_valid);
    end
  endtask

  task automatic test_stream();
    logic [15:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 16'h1000 + 16'(i * 4);
      step(i < 6, a, 2'(i), 1'(i), 0);
      n_checks++;
      if (O_res_ready !== 1'b1 || O_upd_valid !== m_valid ||
          (m_valid && (O_upd_addr !== m_addr || O_upd_state !== m_state || O_upd_taken !== m_taken))) begin
        n_fail++;
        $display("FAIL stream_%0d: ready=%b v=%b addr=%h st=%0d tk=%b, required 1 %b %h %0d %b",
                 i, O_res_ready, O_upd_valid, O_upd_addr, O_upd_state, O_upd_taken,
                 m_valid, m_addr, m_state, m_taken);
      end
    end
    n_checks++;
    if (O_mispred_cnt !== 16'(m_cnt)) begin
      n_fail++; $display("FAIL stream_cnt: cnt=%0d, required %0d", O_mispred_cnt, m_cnt);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) step(1, 16'h2000 + 16'(i), 2'd3, 1'b1, 0);
    step(1, 16'h2FFF, 2'd0, 1'b1, 1);
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (O_upd_valid !== 1'b0 || O_init_valid !== 1'b1 || O_busy !== 1'b1 ||
          O_init_index !== 6'(i) || O_res_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_sweep%0d: upd_v=%b init_v=%b busy=%b idx=%0d ready=%b, required 0 1 1 %0d 0",
                 i, O_upd_valid, O_init_valid, O_busy, O_init_index, O_res_ready, i);
      end
      step(0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (O_busy !== 1'b0 || O_res_ready !== 1'b1 || O_upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_after: busy=%b ready=%b upd_v=%b, required 0 1 0", O_busy, O_res_ready, O_upd_valid);
    end
  endtask

  task automatic test_random();
    bit v, c;
    for (int i = 0; i < 600; i++) begin
      v = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 79) == 0);
      step(v, 16'($urandom), 2'($urandom), 1'($urandom), c);
      n_checks++;
      if (O_upd_valid !== m_valid || O_res_ready !== m_ready || O_busy !== m_sweep ||
          O_init_valid !== m_sweep || O_init_index !== 6'(m_idx) || O_mispred_cnt !== 16'(m_cnt) ||
          (m_valid && (O_upd_addr !== m_addr || O_upd_state !== m_state || O_upd_taken !== m_taken))) begin
        n_fail++;
        $display("FAIL random_%0d: v=%b rdy=%b busy=%b idx=%0d cnt=%0d addr=%h st=%0d tk=%b, required %b %b %b %0d %0d %h %0d %b",
                 i, O_upd_valid, O_res_ready, O_busy, O_init_index, O_mispred_cnt, O_upd_addr,
                 O_upd_state, O_upd_taken, m_valid, m_ready, m_sweep, m_idx, m_cnt, m_addr, m_state, m_taken);
      end
    end
  endtask

  task automatic test_saturate();
    int guard = 0;
    while (m_sweep && guard < 100) begin step(0, 0, 0, 0, 0); guard++; end
    // Every entry mispredicts: predicted taken, actually not taken.
    while (m_cnt < 65535 && guard < 70000) begin
      step(1, 16'($urandom), 2'b10, 1'b0, 0);
      guard++;
    end
    for (int i = 0; i < 4; i++) step(1, 16'h0, 2'b11, 1'b0, 0);
    n_checks++;
    if (O_mispred_cnt !== 16'hFFFF || m_cnt != 65535) begin
      n_fail++; $display("FAIL saturate: cnt=%h, required ffff", O_mispred_cnt);
    end
  endtask

  task automatic test_async_reset();
    #2 rst = 1;
    #1;
    n_checks++;
    if (O_mispred_cnt !== 16'd0 || O_busy !== 1'b1 || O_upd_valid !== 1'b0 ||
        O_res_ready !== 1'b0 || O_init_index !== 6'd0) begin
      n_fail++;
      $display("FAIL async_reset: cnt=%h busy=%b upd_v=%b ready=%b idx=%0d, required 0 1 0 0 0",
               O_mispred_cnt, O_busy, O_upd_valid, O_res_ready, O_init_index);
    end
    model_reset();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_single();
    test_stream();
    test_clear();
    test_random();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
